// File: rtl/alu_arbiter_if.sv
// Request channel from one requester into alu_arbiter: valid/ready handshake carrying
// the operands and the 4-bit ALU opcode.
interface alu_arbiter_if #(
  parameter int unsigned WORD_SIZE = 64
) ();
  logic                 valid;
  logic                 ready;
  logic [WORD_SIZE-1:0] a;
  logic [WORD_SIZE-1:0] b;
  logic [3:0]           op;

  modport master (output valid, a, b, op, input ready);
  modport slave  (input valid, a, b, op, output ready);
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with per-op
// multicycle timing and a buffered response. Optional divide-by-zero trap: ALU_ARB_DIV0_TRAP_EN.
module alu_arbiter #(
  parameter int unsigned WORD_SIZE  = 64,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_arbiter_if.slave         req0_if,
  alu_arbiter_if.slave         req1_if,
  output logic [WORD_SIZE-1:0] alu_a_o,
  output logic [WORD_SIZE-1:0] alu_b_o,
  output logic [3:0]           alu_op_o,
  input  logic [WORD_SIZE-1:0] alu_out_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 resp_id_o,
  output logic [WORD_SIZE-1:0] resp_data_o,
`ifdef ALU_ARB_DIV0_TRAP_EN
  output logic                 resp_err_o,
`endif
  output logic                 busy_o
);

  localparam logic [3:0] AluMul = 4'd10;
  localparam logic [3:0] AluDiv = 4'd11;
  localparam logic [3:0] AluMod = 4'd12;

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 rr_q, rr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]           op_q, op_d;
  logic                 id_q, id_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 rvalid_q, rvalid_d;

  logic                 idle, gnt0, gnt1, accept;
  logic [WORD_SIZE-1:0] sel_a, sel_b;
  logic [3:0]           sel_op;
  logic [CntW-1:0]      sel_cnt;

  // Ready is gated by rst so nothing looks accepted while reset is held.
  assign idle          = (state_q == StIdle) && !rst;
  assign gnt0          = idle && req0_if.valid && !(req1_if.valid && rr_q);
  assign gnt1          = idle && req1_if.valid && !(req0_if.valid && !rr_q);
  assign req0_if.ready = gnt0;
  assign req1_if.ready = gnt1;
  assign accept        = gnt0 || gnt1;

  assign sel_a  = gnt1 ? req1_if.a  : req0_if.a;
  assign sel_b  = gnt1 ? req1_if.b  : req0_if.b;
  assign sel_op = gnt1 ? req1_if.op : req0_if.op;

`ifdef ALU_ARB_DIV0_TRAP_EN
  logic err_q, err_d;
  logic div0_q, div0_d;
  logic sel_div0;

  assign sel_div0 = ((sel_op == AluDiv) || (sel_op == AluMod)) && (sel_b == '0);
`endif

  // Counter preload is latency minus one; everything not MUL/DIV/MOD takes one cycle.
  always_comb begin
    sel_cnt = '0;
    unique case (sel_op)
      AluMul:         sel_cnt = CntW'(MUL_CYCLES - 1);
      AluDiv, AluMod: sel_cnt = CntW'(DIV_CYCLES - 1);
      default:        sel_cnt = '0;
    endcase
`ifdef ALU_ARB_DIV0_TRAP_EN
    if (sel_div0) sel_cnt = '0;
`endif
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    id_d     = id_q;
    data_d   = data_q;
    rvalid_d = rvalid_q;
`ifdef ALU_ARB_DIV0_TRAP_EN
    err_d    = err_q;
    div0_d   = div0_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = sel_a;
          b_d     = sel_b;
          op_d    = sel_op;
          id_d    = gnt1;
          rr_d    = !gnt1;
          cnt_d   = sel_cnt;
          state_d = StExec;
`ifdef ALU_ARB_DIV0_TRAP_EN
          div0_d  = sel_div0;
`endif
        end
      end
      StExec: begin
        if (cnt_q == '0) begin
          data_d   = alu_out_i;
          rvalid_d = 1'b1;
          state_d  = StResp;
`ifdef ALU_ARB_DIV0_TRAP_EN
          err_d    = div0_q;
          if (div0_q) data_d = '1;
`endif
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (resp_ready_i) begin
          rvalid_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_q     <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      id_q     <= 1'b0;
      data_q   <= '0;
      rvalid_q <= 1'b0;
`ifdef ALU_ARB_DIV0_TRAP_EN
      err_q    <= 1'b0;
      div0_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      id_q     <= id_d;
      data_q   <= data_d;
      rvalid_q <= rvalid_d;
`ifdef ALU_ARB_DIV0_TRAP_EN
      err_q    <= err_d;
      div0_q   <= div0_d;
`endif
    end
  end

  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign alu_op_o     = op_q;
  assign resp_valid_o = rvalid_q;
  assign resp_id_o    = id_q;
  assign resp_data_o  = data_q;
  assign busy_o       = (state_q != StIdle);
`ifdef ALU_ARB_DIV0_TRAP_EN
  assign resp_err_o   = err_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic against a
// transaction-level model (grant order, latency, result). Honours ALU_ARB_DIV0_TRAP_EN.
module tb_alu_arbiter;

  localparam int unsigned W      = 64;
  localparam int unsigned MulCyc = 4;
  localparam int unsigned DivCyc = 16;

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpMul = 4'd10;
  localparam logic [3:0] OpDiv = 4'd11;
  localparam logic [3:0] OpMod = 4'd12;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] alu_a, alu_b, alu_out, resp_data;
  logic [3:0]   alu_op;
  logic         resp_valid, resp_ready, resp_id, busy;
`ifdef ALU_ARB_DIV0_TRAP_EN
  logic         resp_err;
`endif

  alu_arbiter_if #(.WORD_SIZE(W)) req0_if ();
  alu_arbiter_if #(.WORD_SIZE(W)) req1_if ();

  alu_arbiter #(
    .WORD_SIZE (W),
    .MUL_CYCLES(MulCyc),
    .DIV_CYCLES(DivCyc)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_if     (req0_if),
    .req1_if     (req1_if),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_op_o    (alu_op),
    .alu_out_i   (alu_out),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_id_o   (resp_id),
    .resp_data_o (resp_data),
`ifdef ALU_ARB_DIV0_TRAP_EN
    .resp_err_o  (resp_err),
`endif
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[5:0];
      4'd6:    return a >> b[5:0];
      4'd10:   return a * b;
      4'd11:   return (b == '0) ? '1 : a / b;
      4'd12:   return (b == '0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  // The shared ALU instance the arbiter drives.
  always_comb alu_out = alu_fn(alu_op, alu_a, alu_b);

  function automatic bit is_div0(input logic [3:0] op, input logic [W-1:0] b);
`ifdef ALU_ARB_DIV0_TRAP_EN
    return ((op == OpDiv) || (op == OpMod)) && (b == '0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int lat_of(input logic [3:0] op, input logic [W-1:0] b);
    if (is_div0(op, b)) return 1;
    if (op == OpMul) return MulCyc;
    if (op == OpDiv || op == OpMod) return DivCyc;
    return 1;
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Requester-side pending operations.
  bit         pend[2];
  logic [W-1:0] p_a[2], p_b[2];
  logic [3:0] p_op[2];

  // Transaction model: one op in flight, edges counted since acceptance.
  bit         m_idle = 1'b1;
  bit         m_last = 1'b1;
  int         m_cnt, m_lat;
  bit         m_id, m_err, m_seen;
  logic [W-1:0] m_a, m_b, m_data;
  logic [3:0] m_op;

  bit         rand_mode = 1'b0;
  bit         drv_rready = 1'b1;
  logic [W-1:0] last_data;
  int         last_lat;
  bit         last_id, last_err;
  int         id_log[$];

  task automatic set_req(input int i, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    pend[i] = 1'b1;
    p_op[i] = op;
    p_a[i]  = a;
    p_b[i]  = b;
  endtask

  task automatic clr_last();
    last_data = '0;
    last_lat  = -1;
    last_id   = 1'b0;
    last_err  = 1'b0;
  endtask

  task automatic cycle();
    bit e0, e1, erv;
    int g;
    if (rand_mode) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, 4'($urandom_range(0, 15)), {$urandom, $urandom},
                  ($urandom_range(0, 3) == 0) ? '0 : {32'($urandom_range(0, 3)), $urandom});
        end
      end
      drv_rready = ($urandom_range(0, 3) != 0);
    end
    req0_if.valid = pend[0]; req0_if.a = p_a[0]; req0_if.b = p_b[0]; req0_if.op = p_op[0];
    req1_if.valid = pend[1]; req1_if.a = p_a[1]; req1_if.b = p_b[1]; req1_if.op = p_op[1];
    resp_ready = drv_rready;
    #2;
    e0  = m_idle && pend[0] && (!pend[1] || m_last);
    e1  = m_idle && pend[1] && (!pend[0] || !m_last);
    erv = !m_idle && (m_cnt >= m_lat);
    check_eq("ready0", req0_if.ready, e0);
    check_eq("ready1", req1_if.ready, e1);
    check_eq("busy", busy, !m_idle);
    check_eq("resp_valid", resp_valid, erv);
    if (!m_idle && m_cnt < m_lat) begin
      check_eq("alu_a", alu_a, m_a);
      check_eq("alu_b", alu_b, m_b);
      check_eq("alu_op", alu_op, m_op);
    end
    if (resp_valid && !m_idle && !m_seen) begin
      m_seen   = 1'b1;
      last_lat = m_cnt;
    end
    if (erv) begin
      check_eq("resp_data", resp_data, m_data);
      check_eq("resp_id", resp_id, m_id);
`ifdef ALU_ARB_DIV0_TRAP_EN
      check_eq("resp_err", resp_err, m_err);
`endif
      if (drv_rready) begin
        last_data = resp_data;
        last_id   = resp_id;
`ifdef ALU_ARB_DIV0_TRAP_EN
        last_err  = resp_err;
`endif
      end
    end
    @(posedge clk);
    #1;
    if (m_idle) begin
      if (e0 || e1) begin
        g      = e1 ? 1 : 0;
        m_idle = 1'b0;
        m_cnt  = 0;
        m_seen = 1'b0;
        m_lat  = lat_of(p_op[g], p_b[g]);
        m_err  = is_div0(p_op[g], p_b[g]);
        m_data = m_err ? '1 : alu_fn(p_op[g], p_a[g], p_b[g]);
        m_a    = p_a[g];
        m_b    = p_b[g];
        m_op   = p_op[g];
        m_id   = g[0];
        m_last = g[0];
        pend[g] = 1'b0;
      end
    end else if (erv && drv_rready) begin
      m_idle = 1'b1;
      id_log.push_back(int'(m_id));
    end else begin
      m_cnt++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Called right after cycle(): asserts rst in the middle of the clock period.
  task automatic mid_reset();
    #4;
    req0_if.valid = 1'b1;
    req1_if.valid = 1'b1;
    rst = 1'b1;
    #1;
    check_eq("rst_busy", busy, '0);
    check_eq("rst_resp_valid", resp_valid, '0);
    check_eq("rst_resp_data", resp_data, '0);
    check_eq("rst_resp_id", resp_id, '0);
    check_eq("rst_alu_a", alu_a, '0);
    check_eq("rst_alu_b", alu_b, '0);
    check_eq("rst_alu_op", alu_op, '0);
    check_eq("rst_ready0", req0_if.ready, '0);
    check_eq("rst_ready1", req1_if.ready, '0);
`ifdef ALU_ARB_DIV0_TRAP_EN
    check_eq("rst_resp_err", resp_err, '0);
`endif
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    m_idle  = 1'b1;
    m_last  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n_log;
    pend[0] = 1'b0; pend[1] = 1'b0;
    p_a[0] = '0; p_b[0] = '0; p_op[0] = '0;
    p_a[1] = '0; p_b[1] = '0; p_op[1] = '0;
    req0_if.valid = 1'b1; req0_if.a = '0; req0_if.b = '0; req0_if.op = '0;
    req1_if.valid = 1'b1; req1_if.a = '0; req1_if.b = '0; req1_if.op = '0;
    resp_ready = 1'b1;
    clr_last();
    repeat (2) @(posedge clk);
    #1;
    check_eq("init_busy", busy, '0);
    check_eq("init_resp_valid", resp_valid, '0);
    check_eq("init_ready0", req0_if.ready, '0);
    check_eq("init_ready1", req1_if.ready, '0);
    check_eq("init_alu_op", alu_op, '0);
    rst = 1'b0;

    // ADD 5+7 from requester 0.
    clr_last();
    set_req(0, OpAdd, 64'd5, 64'd7);
    run(5);
    check_eq("add_data", last_data, 64'd12);
    check_eq("add_id", last_id, '0);
    check_eq("add_lat", 64'(last_lat), 64'd1);

    // Both requesters from reset; requester 0 keeps re-requesting.
    mid_reset();
    id_log.delete();
    set_req(0, OpSub, 64'd9, 64'd4);
    set_req(1, OpSub, 64'd9, 64'd4);
    for (int i = 0; i < 12; i++) begin
      if (!pend[0]) set_req(0, OpSub, 64'd9, 64'd4);
      cycle();
    end
    run(6);
    n_log = id_log.size();
    check_eq("alt_count_ge3", 64'(n_log >= 3), 64'd1);
    if (n_log >= 3) begin
      check_eq("alt_first", 64'(id_log[0]), 64'd0);
      check_eq("alt_second", 64'(id_log[1]), 64'd1);
      check_eq("alt_third", 64'(id_log[2]), 64'd0);
    end
    check_eq("sub_data", last_data, 64'd5);

    // Multicycle ops.
    clr_last();
    set_req(1, OpMul, 64'd3, 64'd4);
    run(8);
    check_eq("mul_data", last_data, 64'd12);
    check_eq("mul_lat", 64'(last_lat), 64'(MulCyc));
    check_eq("mul_id", last_id, 64'd1);
    clr_last();
    set_req(1, OpDiv, 64'd100, 64'd7);
    run(20);
    check_eq("div_data", last_data, 64'd14);
    check_eq("div_lat", 64'(last_lat), 64'(DivCyc));
    clr_last();
    set_req(0, OpMod, 64'd100, 64'd7);
    run(20);
    check_eq("mod_data", last_data, 64'd2);

    // Response back-pressure with the other requester waiting.
    clr_last();
    drv_rready = 1'b0;
    set_req(0, OpAdd, 64'd1, 64'd2);
    run(2);
    set_req(1, OpAdd, 64'd10, 64'd20);
    run(5);
    drv_rready = 1'b1;
    run(8);
    check_eq("stall_data", last_data, 64'd30);

    // Reset during DIV: nothing may come back.
    set_req(0, OpDiv, 64'd100, 64'd7);
    run(6);
    n_log = id_log.size();
    mid_reset();
    run(25);
    check_eq("no_resp_after_rst", 64'(id_log.size()), 64'(n_log));

    // Divide by zero.
    clr_last();
    set_req(0, OpDiv, 64'd8, 64'd0);
    run(20);
`ifdef ALU_ARB_DIV0_TRAP_EN
    check_eq("div0_lat", 64'(last_lat), 64'd1);
    check_eq("div0_data", last_data, '1);
    check_eq("div0_err", last_err, 64'd1);
`else
    check_eq("div0_lat", 64'(last_lat), 64'(DivCyc));
`endif

    // Random traffic with one reset in the middle.
    rand_mode = 1'b1;
    run(1500);
    mid_reset();
    run(1500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
